commit_retire_ctrl: RTL
=======================

COMMIT_RETIRE_CTRL -- requirements
Module: commit_retire_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: number of cycles flush is held after a redirect or trap (legal range 1..15).
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port commit_valid  input  1  completion-buffer head is ready to retire (scalar commit enable).
REQ-005 SHALL have port commit_vd  input  5  destination register of the head entry.
REQ-006 SHALL have port commit_wdata  input  32 (word_t)  result of the head entry.
REQ-007 SHALL have port commit_wen  input  1  head entry writes a destination register.
REQ-008 SHALL have port commit_exception  input  1  head entry carries an exception.
REQ-009 SHALL have port commit_mispredict  input  1  head entry is a mispredicted branch/jump.
REQ-010 SHALL have ports commit_pc / commit_target  input  32 each  head PC; correct redirect target.
REQ-011 SHALL have ports vcommit_req / vcommit_done  input  1 each  head is a vector instruction; vector pipe finished committing it.
REQ-012 SHALL have port halt_instr  input  1  head entry is a halt instruction.
REQ-013 SHALL have ports rf_wen  output  1, rf_waddr  output  5, rf_wdata  output  32  scalar register-file write.
REQ-014 SHALL have ports flush  output  1, commit_stall  output  1  pipeline flush; completion buffer must not advance its head.
REQ-015 SHALL have ports redirect_valid  output  1, redirect_pc  output  32  fetch redirect.
REQ-016 SHALL have ports trap_req  output  1, epc  output  32  trap request and faulting PC.
REQ-017 SHALL have ports halted  output  1, instret  output  64  sticky halt; retired-instruction count.

Function
REQ-018 SHALL implement FSM states RUN, VWAIT, FLUSH, HALT; commit_stall SHALL equal (state != RUN), combinational from state only.
REQ-019 In RUN, commit_valid with no exception/mispredict/vector/halt SHALL retire: rf_* registered, visible exactly 1 cycle later for exactly 1 cycle; instret +1 on the same edge.
REQ-020 rf_wen SHALL be 0 when commit_wen=0 or commit_vd=0 (x0); instret still increments.
REQ-021 Mispredict in RUN: retire as REQ-019, pulse redirect_valid 1 cycle with redirect_pc=commit_target, assert flush, go to FLUSH.
REQ-022 Exception in RUN: no rf write, no instret increment, pulse trap_req 1 cycle, capture epc=commit_pc (held until next trap), assert flush, go to FLUSH.
REQ-023 Exception SHALL take priority over mispredict, vector and halt when several are asserted together.
REQ-024 FLUSH: flush high for exactly FLUSH_CYCLES consecutive cycles (4-bit down-counter loaded on entry), then return to RUN; commit_valid ignored throughout.
REQ-025 vcommit_req with commit_valid in RUN: go to VWAIT, no rf write; on vcommit_done increment instret, return to RUN next cycle; vcommit_done outside VWAIT ignored.
REQ-026 halt_instr with commit_valid in RUN: retire as REQ-019, go to HALT; halted=1 and commit_stall=1 until reset.
REQ-027 Any commit_valid while commit_stall=1 SHALL have no effect (buffer holds the entry).
REQ-028 instret SHALL wrap modulo 2^64 with no saturation or flag.

Reset
REQ-029 On nRST low, immediately: state=RUN, counter=0, instret=0, epc=0, all outputs 0, regardless of state (including mid-FLUSH or VWAIT).
REQ-030 First retirement SHALL be possible on the first rising edge after nRST deasserts.

Structure
REQ-031 word_t and enum commit_state_t (RUN, VWAIT, FLUSH, HALT) SHALL live in rv32i_types_pkg; FLUSH_CYCLES stays a module parameter.
REQ-032 No sub-module: FSM, flush counter, instret counter and output registers SHALL be inline.

Verification
REQ-033 Retire vd=5, wdata=0xDEADBEEF, wen=1 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, instret=1.
REQ-034 Retire vd=0, wen=1 -> rf_wen stays 0, instret increments by 1.
REQ-035 Mispredict, target=0x80000100, FLUSH_CYCLES=2 -> redirect_valid 1 cycle with redirect_pc=0x80000100, flush exactly 2 cycles, commit_stall high during FLUSH, RUN resumes.
REQ-036 Exception+mispredict together, pc=0x00000040 -> trap_req pulse, epc=0x00000040, no redirect, no rf write, instret unchanged.
REQ-037 vcommit_req, vcommit_done after 5 cycles -> commit_stall high 5 cycles, instret +1; then nRST pulse mid-FLUSH -> all outputs 0, state RUN.
REQ-038 Preload instret=2^64-1 via retirements/force, retire once -> instret=0; halt_instr retire -> halted=1 sticky, later commit_valid ignored.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared types for the RV32I commit path: data word and commit FSM states.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    VWAIT = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } commit_state_t;

endpackage

// File: rtl/commit_retire_ctrl.sv
// In-order retire controller: scalar RF writeback, redirect/trap flush sequencing,
// vector-commit handshake, sticky halt and 64-bit retired-instruction counter.
module commit_retire_ctrl
  import rv32i_types_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        commit_valid,
  input  logic [4:0]  commit_vd,
  input  word_t       commit_wdata,
  input  logic        commit_wen,
  input  logic        commit_exception,
  input  logic        commit_mispredict,
  input  word_t       commit_pc,
  input  word_t       commit_target,
  input  logic        vcommit_req,
  input  logic        vcommit_done,
  input  logic        halt_instr,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output word_t       rf_wdata,
  output logic        flush,
  output logic        commit_stall,
  output logic        redirect_valid,
  output word_t       redirect_pc,
  output logic        trap_req,
  output word_t       epc,
  output logic        halted,
  output logic [63:0] instret
);

  // Counter holds remaining FLUSH cycles after the current one.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  commit_state_t state;
  logic [3:0]    flush_cnt;

  assign commit_stall = (state != RUN);
  assign flush        = (state == FLUSH);
  assign halted       = (state == HALT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state          <= RUN;
      flush_cnt      <= '0;
      instret        <= '0;
      epc            <= '0;
      rf_wen         <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      trap_req       <= 1'b0;
    end else begin
      rf_wen         <= 1'b0;
      redirect_valid <= 1'b0;
      trap_req       <= 1'b0;
      case (state)
        RUN: begin
          if (commit_valid) begin
            if (commit_exception) begin
              trap_req  <= 1'b1;
              epc       <= commit_pc;
              flush_cnt <= FLUSH_LOAD;
              state     <= FLUSH;
            end else if (vcommit_req && !commit_mispredict) begin
              state <= VWAIT;
            end else begin
              rf_wen   <= commit_wen && (commit_vd != 5'd0);
              rf_waddr <= commit_vd;
              rf_wdata <= commit_wdata;
              instret  <= instret + 64'd1;
              if (commit_mispredict) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= commit_target;
                flush_cnt      <= FLUSH_LOAD;
                state          <= FLUSH;
              end else if (halt_instr) begin
                state <= HALT;
              end
            end
          end
        end
        VWAIT: begin
          if (vcommit_done) begin
            instret <= instret + 64'd1;
            state   <= RUN;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) state <= RUN;
          else                   flush_cnt <= flush_cnt - 4'd1;
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule
